rr_arb8: RTL
============

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of consecutive cycles one grant may be held (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  8  request vector; requester id k drives req[7-k] (id 0 = req[7], id 7 = req[0]).
REQ-005 gnt  output  8  one-hot grant, bit positions matching req; all-zero when no grant.
REQ-006 gnt_id  output  3  encoded id of granted requester (7 minus bit position); 3'b000 when gnt_valid=0.
REQ-007 gnt_valid  output  1  high while any grant is held.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 The controller SHALL implement states IDLE and GRANT, both encoded in the package enum.
REQ-010 In IDLE with (req & ~mask) nonzero, the controller SHALL register a grant and enter GRANT on the next edge (1-cycle req-to-gnt latency).
REQ-011 Arbitration SHALL be round-robin: search ids starting at pointer ptr, ascending, wrapping 7->0; first eligible id wins.
REQ-012 Eligible SHALL mean req bit high and mask bit low.
REQ-013 In GRANT, gnt/gnt_id/gnt_valid SHALL remain stable and are not affected by other req changes.
REQ-014 If the granted requester's req bit is low in GRANT, the controller SHALL return to IDLE on the next edge, clear gnt, and set ptr = granted id + 1 (mod 8).
REQ-015 After any release, at least one cycle with gnt_valid=0 SHALL follow before the next grant (no back-to-back grants).
REQ-016 A hold counter SHALL load 1 on entry to GRANT and increment each GRANT cycle; it SHALL saturate and not wrap.
REQ-017 When the hold counter equals MAX_HOLD and the granted req is still high, the controller SHALL revoke: go to IDLE, clear gnt, pulse timeout for exactly that one cycle, set ptr = granted id + 1, and set mask bit of that id.
REQ-018 Normal release (REQ-014) and timeout in the same cycle SHALL be treated as normal release: no timeout pulse, no mask set.
REQ-019 A mask bit SHALL clear on the cycle after the corresponding req bit is observed low; masked requesters are ineligible until then.
REQ-020 If all requesting ids are masked, the controller SHALL stay in IDLE with gnt_valid=0.
REQ-021 req with zero eligible bits in IDLE SHALL leave all state unchanged.
REQ-022 Exactly one gnt bit SHALL be high whenever gnt_valid=1; gnt_id SHALL always equal the encoding of gnt.

Reset
REQ-023 On rst_n low, state SHALL become IDLE, gnt=8'h00, gnt_id=3'b000, gnt_valid=0, timeout=0, ptr=0, mask=8'h00, hold counter=0, immediately and asynchronously.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant without a timeout pulse; first grant after reset release SHALL follow REQ-010 with ptr=0.

Structure
REQ-025 Package rr_arb_pkg SHALL hold N_REQ=8, ID_W=3, the state enum, and the id-to-bit-position mapping function.
REQ-026 One sub-module arb_prio_enc SHALL be used: combinational 8-bit priority encoder over the rotated eligible vector, outputs found flag and 3-bit offset.
REQ-027 All outputs SHALL be driven directly from registers.

Verification
REQ-028 Reset then req=8'h81 held -> 1 cycle later gnt=8'h80, gnt_id=0; drop req[7] -> gnt=0 next cycle, then gnt=8'h01, gnt_id=7 after the mandatory idle cycle.
REQ-029 req=8'hFF held, each grantee drops req 3 cycles after grant then reasserts -> grant order ids 0,1,2,...,7,0 with one idle cycle between grants.
REQ-030 MAX_HOLD=4, req=8'h40 held -> gnt=8'h40 for 4 cycles, timeout pulses once, gnt=0; id 1 not regranted until req[6] drops for a cycle and rises again.
REQ-031 Grant id 2 and drop req[5] on exactly the cycle hold counter reaches MAX_HOLD -> no timeout pulse, mask stays 8'h00.
REQ-032 rst_n asserted low during GRANT of id 5 -> gnt=0, timeout=0 immediately; after release with req=8'h24 -> id 2 granted first.
REQ-033 Random req for 10k cycles -> assertions: gnt one-hot or zero, gnt_id consistent, timeout never two consecutive cycles, no grant lasts over MAX_HOLD cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and id/bit-position helpers for the 8-way round-robin arbiter.
// Requester id k sits on request bit (N_REQ-1-k), so id 0 is the MSB.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [ID_W-1:0] id2pos(input logic [ID_W-1:0] id);
    return ID_W'(N_REQ - 1) - id;
  endfunction

  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v = '0;
    v[id2pos(id)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Priority encoder over the pointer-rotated eligible vector.
// Bit 0 is the highest priority; the offset is added back to the pointer by the caller.
import rr_arb_pkg::*;

module arb_prio_enc (
  input  logic [N_REQ-1:0] i_vec,
  output logic             o_found,
  output logic [ID_W-1:0]  o_ofs
);

  always_comb begin
    o_found = |i_vec;
    o_ofs   = '0;
    // Descending scan so the lowest set bit is the last (winning) assignment.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_vec[i]) o_ofs = ID_W'(i);
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with a hold limit that revokes and masks a hogging requester.
// All outputs come straight from registers.
import rr_arb_pkg::*;

module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  // state    | meaning
  // ST_IDLE  | no grant held; arbitrate among eligible requesters
  // ST_GRANT | one requester granted; watch its req and the hold counter

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t           r_state, w_state_n;
  logic [N_REQ-1:0] r_gnt, w_gnt_n;
  logic [ID_W-1:0]  r_gnt_id, w_gnt_id_n;
  logic             r_gnt_valid, w_gnt_valid_n;
  logic             r_timeout, w_timeout_n;
  logic [ID_W-1:0]  r_ptr, w_ptr_n;
  logic [N_REQ-1:0] r_mask, w_mask_n, w_mask_set;
  logic [7:0]       r_hold, w_hold_n;

  logic [N_REQ-1:0] w_elig_id, w_rot;
  logic [ID_W-1:0]  w_idx, w_ofs, w_win_id;
  logic             w_found, w_gnt_req;

  // w_elig_id is indexed by requester id, w_rot by distance from the pointer.
  always_comb begin
    w_elig_id = '0;
    w_rot     = '0;
    w_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_elig_id[k] = req[id2pos(ID_W'(k))] & ~r_mask[id2pos(ID_W'(k))];
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_idx    = r_ptr + ID_W'(i);
      w_rot[i] = w_elig_id[w_idx];
    end
  end

  arb_prio_enc u_prio_enc (
    .i_vec   (w_rot),
    .o_found (w_found),
    .o_ofs   (w_ofs)
  );

  assign w_win_id  = r_ptr + w_ofs;
  assign w_gnt_req = req[id2pos(r_gnt_id)];

  always_comb begin
    w_state_n     = r_state;
    w_gnt_n       = r_gnt;
    w_gnt_id_n    = r_gnt_id;
    w_gnt_valid_n = r_gnt_valid;
    w_timeout_n   = 1'b0;
    w_ptr_n       = r_ptr;
    w_hold_n      = r_hold;
    w_mask_set    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_n     = ST_GRANT;
          w_gnt_n       = id2onehot(w_win_id);
          w_gnt_id_n    = w_win_id;
          w_gnt_valid_n = 1'b1;
          w_hold_n      = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!w_gnt_req || r_hold == HOLD_LIM) begin
          w_state_n     = ST_IDLE;
          w_gnt_n       = '0;
          w_gnt_id_n    = '0;
          w_gnt_valid_n = 1'b0;
          w_ptr_n       = r_gnt_id + ID_W'(1);
          w_hold_n      = '0;
          // A voluntary release on the limit cycle wins over the revoke.
          if (w_gnt_req) begin
            w_timeout_n = 1'b1;
            w_mask_set  = r_gnt;
          end
        end else begin
          w_hold_n = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_mask_n = (r_mask & req) | w_mask_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_mask      <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_gnt       <= w_gnt_n;
      r_gnt_id    <= w_gnt_id_n;
      r_gnt_valid <= w_gnt_valid_n;
      r_timeout   <= w_timeout_n;
      r_ptr       <= w_ptr_n;
      r_mask      <= w_mask_n;
      r_hold      <= w_hold_n;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
